// File: rtl/core_pkg.sv
// Shared core definitions: sequencer state, reset/exception vectors, cause codes
// and the bundle of candidate next-PC targets.
package core_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned JT_W    = 26;
  localparam int unsigned CAUSE_W = 5;

  localparam logic [XLEN-1:0]    RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [XLEN-1:0]    EXC_VEC_DEF   = 32'h0000_0080;

  localparam logic [CAUSE_W-1:0] CAUSE_ADEL    = 5'd4;
  localparam logic [CAUSE_W-1:0] CAUSE_SYSCALL = 5'd8;
  localparam logic [CAUSE_W-1:0] CAUSE_OVF     = 5'd12;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2,
    ST_HALT = 2'd3
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] br;
    logic [XLEN-1:0] jmp;
    logic            adel;
  } pc_targets_t;

endpackage

// File: rtl/pc_target_calc.sv
// Combinational next-PC candidates (sequential, branch, jump) and the
// misaligned jump-register check.
module pc_target_calc
  import core_pkg::*;
(
  input  logic [XLEN-1:0] i_pc_q,
  input  logic [XLEN-1:0] i_branch_off,
  input  logic [JT_W-1:0] i_jump_target,
  input  logic            i_jump_reg,
  input  logic [1:0]      i_jr_lsb,
  output pc_targets_t     o_tgt_c
);

  logic [XLEN-1:0] w_pc4;

  assign w_pc4 = i_pc_q + XLEN'(4);

  // All sums wrap modulo 2^32.
  assign o_tgt_c.pc4  = w_pc4;
  assign o_tgt_c.br   = w_pc4 + (i_branch_off << 2);
  assign o_tgt_c.jmp  = {w_pc4[XLEN-1:XLEN-4], i_jump_target, 2'b00};
  assign o_tgt_c.adel = i_jump_reg & (i_jr_lsb != 2'b00);

endmodule

// File: rtl/pc_next_sequencer.sv
// Next-PC controller: drives the PC register write port, sequences boot,
// captures EPC/cause on exception entry and halts on a double fault.
module pc_next_sequencer
  import core_pkg::*;
#(
  parameter logic [XLEN-1:0]    RESET_VEC = RESET_VEC_DEF,
  parameter logic [XLEN-1:0]    EXC_VEC   = EXC_VEC_DEF,
  parameter logic [CAUSE_W-1:0] ADEL_CODE = CAUSE_ADEL
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [XLEN-1:0]    i_pc_q,
  input  logic               i_stall,
  input  logic               i_branch_taken,
  input  logic [XLEN-1:0]    i_branch_off,
  input  logic               i_jump,
  input  logic [JT_W-1:0]    i_jump_target,
  input  logic               i_jump_reg,
  input  logic [XLEN-1:0]    i_jr_addr,
  input  logic               i_exc_req,
  input  logic [CAUSE_W-1:0] i_exc_code,
  input  logic               i_eret,
  output logic               o_pc_we,
  output logic [XLEN-1:0]    o_pc_d,
  output logic [XLEN-1:0]    o_epc,
  output logic [CAUSE_W-1:0] o_cause,
  output logic               o_in_trap,
  output logic               o_halted
);

  state_e             r_state;
  state_e             w_state_nxt;
  logic [XLEN-1:0]    r_epc;
  logic [CAUSE_W-1:0] r_cause;
  logic               w_exc_entry;
  pc_targets_t        w_tgt;

  pc_target_calc u_calc (
    .i_pc_q        (i_pc_q),
    .i_branch_off  (i_branch_off),
    .i_jump_target (i_jump_target),
    .i_jump_reg    (i_jump_reg),
    .i_jr_lsb      (i_jr_addr[1:0]),
    .o_tgt_c       (w_tgt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BOOT;
      r_epc   <= '0;
      r_cause <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_exc_entry) begin
        r_epc   <= i_pc_q;
        r_cause <= i_exc_code_sel();
      end
    end
  end

  function automatic logic [CAUSE_W-1:0] i_exc_code_sel();
    return i_exc_req ? i_exc_code : ADEL_CODE;
  endfunction

  // Next-PC priority: exception, stall, eret (TRAP only), jr, j, branch, pc+4.
  always_comb begin
    w_state_nxt = r_state;
    w_exc_entry = 1'b0;
    o_pc_we     = 1'b0;
    o_pc_d      = i_pc_q;
    if (reset) begin
      o_pc_d = '0;
    end else begin
      case (r_state)
        ST_BOOT: begin
          o_pc_we     = 1'b1;
          o_pc_d      = RESET_VEC;
          w_state_nxt = ST_RUN;
        end
        ST_RUN, ST_TRAP: begin
          if (i_exc_req || w_tgt.adel) begin
            if (r_state == ST_RUN) begin
              o_pc_we     = 1'b1;
              o_pc_d      = EXC_VEC;
              w_exc_entry = 1'b1;
              w_state_nxt = ST_TRAP;
            end else begin
              w_state_nxt = ST_HALT;
            end
          end else if (i_stall) begin
            o_pc_we = 1'b0;
          end else if (i_eret && (r_state == ST_TRAP)) begin
            o_pc_we     = 1'b1;
            o_pc_d      = r_epc + XLEN'(4);
            w_state_nxt = ST_RUN;
          end else begin
            o_pc_we = 1'b1;
            if (i_jump_reg)          o_pc_d = i_jr_addr;
            else if (i_jump)         o_pc_d = w_tgt.jmp;
            else if (i_branch_taken) o_pc_d = w_tgt.br;
            else                     o_pc_d = w_tgt.pc4;
          end
        end
        default: begin
          w_state_nxt = ST_HALT;
        end
      endcase
    end
  end

  assign o_epc     = r_epc;
  assign o_cause   = r_cause;
  assign o_in_trap = (r_state == ST_TRAP);
  assign o_halted  = (r_state == ST_HALT);

endmodule

// File: tb/tb_pc_next_sequencer.sv
// Scoreboard bench for pc_next_sequencer: directed scenarios then random
// traffic, checked against a rule-level reference model.
module tb_pc_next_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_pc_q;
  logic        i_stall, i_branch_taken, i_jump, i_jump_reg, i_exc_req, i_eret;
  logic [31:0] i_branch_off, i_jr_addr;
  logic [25:0] i_jump_target;
  logic [4:0]  i_exc_code;
  logic        o_pc_we, o_in_trap, o_halted;
  logic [31:0] o_pc_d, o_epc;
  logic [4:0]  o_cause;

  always #5 clk = ~clk;

  pc_next_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .i_pc_q         (i_pc_q),
    .i_stall        (i_stall),
    .i_branch_taken (i_branch_taken),
    .i_branch_off   (i_branch_off),
    .i_jump         (i_jump),
    .i_jump_target  (i_jump_target),
    .i_jump_reg     (i_jump_reg),
    .i_jr_addr      (i_jr_addr),
    .i_exc_req      (i_exc_req),
    .i_exc_code     (i_exc_code),
    .i_eret         (i_eret),
    .o_pc_we        (o_pc_we),
    .o_pc_d         (o_pc_d),
    .o_epc          (o_epc),
    .o_cause        (o_cause),
    .o_in_trap      (o_in_trap),
    .o_halted       (o_halted)
  );

  typedef struct {
    logic        rst, stall, br, j, jr, exc, eret;
    logic [31:0] off, jra;
    logic [25:0] jt;
    logic [4:0]  code;
  } stim_t;

  typedef struct {
    logic        we;
    logic [31:0] d;
    logic        chk_d;
    logic        chk_regs;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        in_trap, halted;
  } exp_t;

  localparam int M_UNK = 0, M_BOOT = 1, M_RUN = 2, M_TRAP = 3, M_HALT = 4;

  int          m_mode = M_UNK;
  logic [31:0] m_pc   = 32'h0;
  logic [31:0] m_epc  = 32'h0;
  logic [4:0]  m_cause = 5'h0;
  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.stall = 0; s.br = 0; s.j = 0; s.jr = 0; s.exc = 0; s.eret = 0;
    s.off = 0; s.jra = 0; s.jt = 0; s.code = 0;
    return s;
  endfunction

  // Reference model: one call per cycle, returns what the DUT must show this cycle.
  task automatic model(input stim_t s, output exp_t e);
    logic adel;
    e.chk_regs = (m_mode != M_UNK);
    e.epc      = m_epc;
    e.cause    = m_cause;
    e.in_trap  = (m_mode == M_TRAP);
    e.halted   = (m_mode == M_HALT);
    e.we       = 0;
    e.d        = m_pc;
    e.chk_d    = 0;
    adel = s.jr && (s.jra % 4 != 0);
    if (s.rst) begin
      e.d = 0; e.chk_d = 1;
      m_mode = M_BOOT; m_epc = 0; m_cause = 0;
    end else if (m_mode == M_BOOT) begin
      e.we = 1; e.d = 32'h0; e.chk_d = 1; m_mode = M_RUN;
    end else if (m_mode == M_HALT) begin
      e.d = m_pc; e.chk_d = 1;
    end else if (s.exc || adel) begin
      if (m_mode == M_RUN) begin
        e.we = 1; e.d = 32'h80; e.chk_d = 1;
        m_epc = m_pc; m_cause = s.exc ? s.code : 5'd4; m_mode = M_TRAP;
      end else begin
        m_mode = M_HALT;
      end
    end else if (s.stall) begin
      e.we = 0;
    end else if (s.eret && m_mode == M_TRAP) begin
      e.we = 1; e.d = m_epc + 4; e.chk_d = 1; m_mode = M_RUN;
    end else begin
      e.we = 1; e.chk_d = 1;
      if (s.jr)      e.d = s.jra;
      else if (s.j)  e.d = ((m_pc + 4) & 32'hF000_0000) | (32'(s.jt) * 4);
      else if (s.br) e.d = m_pc + 4 + s.off * 4;
      else           e.d = m_pc + 4;
    end
    if (e.we) m_pc = e.d;
  endtask

  task automatic drive(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    reset = s.rst; i_pc_q = m_pc; i_stall = s.stall; i_branch_taken = s.br;
    i_branch_off = s.off; i_jump = s.j; i_jump_target = s.jt; i_jump_reg = s.jr;
    i_jr_addr = s.jra; i_exc_req = s.exc; i_exc_code = s.code; i_eret = s.eret;
    model(s, e);
    q.push_back(e);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Monitor: pops one expectation per cycle, mid-cycle away from the clock edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      cmp("pc_we", 32'(o_pc_we), 32'(e.we));
      if (e.chk_d) cmp("pc_d", o_pc_d, e.d);
      if (e.chk_regs) begin
        cmp("epc", o_epc, e.epc);
        cmp("cause", 32'(o_cause), 32'(e.cause));
        cmp("in_trap", 32'(o_in_trap), 32'(e.in_trap));
        cmp("halted", 32'(o_halted), 32'(e.halted));
      end
    end
  end

  initial begin
    stim_t s;
    reset = 1; i_pc_q = 0; i_stall = 0; i_branch_taken = 0; i_branch_off = 0;
    i_jump = 0; i_jump_target = 0; i_jump_reg = 0; i_jr_addr = 0;
    i_exc_req = 0; i_exc_code = 0; i_eret = 0;

    // Boot then sequential fetch
    s = idle(); s.rst = 1; drive(s); drive(s);
    repeat (5) drive(idle());

    // Branch backwards and jump-over-branch priority
    m_pc = 32'h100; s = idle(); s.br = 1; s.off = 32'hFFFF_FFFE; drive(s);
    m_pc = 32'h100; s = idle(); s.br = 1; s.j = 1; s.jt = 26'h40; s.off = 32'h10; drive(s);

    // Exception entry and return
    m_pc = 32'h200; s = idle(); s.exc = 1; s.code = 5'd8; drive(s);
    repeat (2) drive(idle());
    s = idle(); s.eret = 1; drive(s);
    drive(idle());
    s = idle(); s.eret = 1; drive(s);

    // Misaligned and aligned jump-register
    s = idle(); s.jr = 1; s.jra = 32'h1002; drive(s);
    s = idle(); s.eret = 1; drive(s);
    s = idle(); s.jr = 1; s.jra = 32'h1004; drive(s);

    // Stall holds; exception overrides stall
    s = idle(); s.stall = 1; s.br = 1; s.off = 32'h40;
    repeat (4) drive(s);
    s.exc = 1; s.code = 5'd12; drive(s);
    s = idle(); s.eret = 1; drive(s);

    // Double fault, halt, recovery by reset
    s = idle(); s.exc = 1; s.code = 5'd8; drive(s);
    s = idle(); s.exc = 1; s.eret = 1; s.code = 5'd12; drive(s);
    s = idle(); s.jr = 1; s.jra = 32'h3000;
    repeat (10) drive(s);
    s = idle(); s.rst = 1; drive(s);
    repeat (3) drive(idle());

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      s = idle();
      s.rst   = ($urandom_range(0, 99) == 0);
      s.stall = ($urandom_range(0, 4) == 0);
      s.br    = $urandom_range(0, 1);
      s.off   = $urandom;
      s.j     = ($urandom_range(0, 3) == 0);
      s.jt    = 26'($urandom);
      s.jr    = ($urandom_range(0, 5) == 0);
      s.jra   = $urandom_range(0, 1) ? ($urandom & 32'hFFFF_FFFC) : $urandom;
      s.exc   = ($urandom_range(0, 15) == 0);
      s.code  = 5'($urandom);
      s.eret  = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 19) == 0) m_pc = $urandom;
      drive(s);
    end

    @(posedge clk);
    @(negedge clk); #1;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
